// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared states, song/mode codes and defaults for the piano player
package piano_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_LEN,
    ST_FETCH_NOTE,
    ST_PLAY,
    ST_GAP,
    ST_PAUSED
  } seq_state_t;

  localparam logic [1:0] SONG_NONE = 2'b00;
  localparam logic [1:0] SONG_LS   = 2'b01;
  localparam logic [1:0] SONG_HB   = 2'b10;
  localparam logic [1:0] SONG_JB   = 2'b11;

  typedef enum logic [1:0] {
    IDLE_MODE,
    PLAY_MODE,
    LEARN_MODE
  } mode_t;

  localparam int unsigned DEFAULT_GAP_CYCLES = 10_000_000;

  // States that a high pause level may freeze
  function automatic logic is_pausable(seq_state_t s);
    return (s == ST_FETCH_NOTE) || (s == ST_PLAY) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/dur_timer.sv
// rtl/dur_timer.sv - loadable down-counter with hold and expiry flag, shared by note and gap timing
module dur_timer #(
  parameter int DUR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [DUR_W-1:0] cnt_q, cnt_d;

  // Load wins over counting; counting saturates at zero and only runs while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - DUR_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - single-address-bus playback sequencer for the note/duration ROM pair
module song_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int          ROM_LAT    = 1,
  parameter int          ADDR_W     = 7,
  parameter int          DUR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic [1:0]        song_sel,
  output logic [1:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [9:0]        note_and_pitch,
  output logic [ADDR_W-1:0] index,
  output logic              busy,
  output logic              done
);

  localparam int              LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : '0;

  seq_state_t        state_q, state_d;
  seq_state_t        ret_q, ret_d;
  logic [1:0]        rom_sel_q, rom_sel_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [9:0]        note_q, note_d;
  logic [9:0]        note_and_pitch_q, note_and_pitch_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic [DUR_W-1:0]  tmr_val;
  logic              tmr_en;
  logic              tmr_expired;
  logic              lat_done;

  assign lat_done = (lat_cnt_q == LAT_LAST);
  // The timer counts the cycle just spent in PLAY/GAP, including the cycle a pause is taken
  assign tmr_en   = (state_q == ST_PLAY) || (state_q == ST_GAP);

  dur_timer #(.DUR_W(DUR_W)) u_dur_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  // Next state: normal sequencing, then pause overlay, then start, then stop (highest)
  always_comb begin
    state_d          = state_q;
    ret_d            = ret_q;
    rom_sel_d        = rom_sel_q;
    rom_addr_d       = rom_addr_q;
    index_d          = index_q;
    length_d         = length_q;
    note_d           = note_q;
    lat_cnt_d        = lat_cnt_q;
    note_and_pitch_d = '0;
    done_d           = 1'b0;
    tmr_load         = 1'b0;
    tmr_val          = '0;

    case (state_q)
      ST_FETCH_LEN: begin
        if (lat_done) begin
          length_d = rom_note[ADDR_W-1:0];
          if (rom_note[ADDR_W-1:0] == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rom_addr_d = ADDR_W'(1);
            lat_cnt_d  = '0;
            state_d    = ST_FETCH_NOTE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_FETCH_NOTE: begin
        if (lat_done) begin
          note_d           = rom_note;
          note_and_pitch_d = rom_note;
          tmr_load         = 1'b1;
          tmr_val          = (rom_dur == '0) ? '0 : rom_dur - DUR_W'(1);
          state_d          = ST_PLAY;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_PLAY: begin
        note_and_pitch_d = note_q;
        if (tmr_expired) begin
          note_and_pitch_d = '0;
          tmr_load         = 1'b1;
          tmr_val          = GAP_LOAD;
          state_d          = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          if (index_q >= length_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            index_d    = index_q + ADDR_W'(1);
            rom_addr_d = index_q + ADDR_W'(1);
            lat_cnt_d  = '0;
            state_d    = ST_FETCH_NOTE;
          end
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d          = ret_q;
          lat_cnt_d        = '0;
          note_and_pitch_d = (ret_q == ST_PLAY) ? note_q : '0;
        end
      end
      default: ;
    endcase

    if (pause && is_pausable(state_q) && is_pausable(state_d)) begin
      ret_d            = state_d;
      state_d          = ST_PAUSED;
      note_and_pitch_d = '0;
    end

    if (start) begin
      if (song_sel != SONG_NONE) begin
        rom_sel_d        = song_sel;
        index_d          = ADDR_W'(1);
        rom_addr_d       = '0;
        lat_cnt_d        = '0;
        tmr_load         = 1'b0;
        note_and_pitch_d = '0;
        done_d           = 1'b0;
        state_d          = ST_FETCH_LEN;
      end else if (state_q != ST_IDLE) begin
        note_and_pitch_d = '0;
        done_d           = 1'b0;
        state_d          = ST_IDLE;
      end
    end

    if (stop) begin
      note_and_pitch_d = '0;
      done_d           = 1'b0;
      state_d          = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      ret_q            <= ST_IDLE;
      rom_sel_q        <= SONG_NONE;
      rom_addr_q       <= '0;
      index_q          <= '0;
      length_q         <= '0;
      note_q           <= '0;
      note_and_pitch_q <= '0;
      lat_cnt_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      ret_q            <= ret_d;
      rom_sel_q        <= rom_sel_d;
      rom_addr_q       <= rom_addr_d;
      index_q          <= index_d;
      length_q         <= length_d;
      note_q           <= note_d;
      note_and_pitch_q <= note_and_pitch_d;
      lat_cnt_q        <= lat_cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign rom_sel        = rom_sel_q;
  assign rom_addr       = rom_addr_q;
  assign index          = index_q;
  assign note_and_pitch = note_and_pitch_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer
module tb_song_sequencer;

  localparam int ADDR_W = 7;
  localparam int DUR_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              pause;
  logic              stop;
  logic [1:0]        song_sel;
  logic [1:0]        rom_sel;
  logic [ADDR_W-1:0] rom_addr;
  logic [9:0]        rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic [9:0]        note_and_pitch;
  logic [ADDR_W-1:0] index;
  logic              busy;
  logic              done;

  song_sequencer #(
    .GAP_CYCLES (4),
    .ROM_LAT    (1),
    .ADDR_W     (ADDR_W),
    .DUR_W      (DUR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pause          (pause),
    .stop           (stop),
    .song_sel       (song_sel),
    .rom_sel        (rom_sel),
    .rom_addr       (rom_addr),
    .rom_note       (rom_note),
    .rom_dur        (rom_dur),
    .note_and_pitch (note_and_pitch),
    .index          (index),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ROM pair: data follows the registered address (one cycle latency)
  logic [9:0]       note_mem [0:3][0:127];
  logic [DUR_W-1:0] dur_mem  [0:3][0:127];
  assign rom_note = note_mem[rom_sel][rom_addr];
  assign rom_dur  = dur_mem[rom_sel][rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, want %s", name, got, want);
  endfunction

  typedef struct {
    int         c;
    logic [9:0] np;
    logic       dn;
  } ev_t;
  ev_t exp_q[$];

  function automatic void exp_ev(input int c, input logic [9:0] np, input logic dn);
    ev_t e;
    e.c = c; e.np = np; e.dn = dn;
    exp_q.push_back(e);
  endfunction

  // Monitor: every change on the buzzer bus and every done pulse is an event
  logic [9:0] prev_np = '0;
  always @(negedge clk) begin
    if ((note_and_pitch != prev_np) || (done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1'b0,
              $sformatf("cyc=%0d np=%h done=%b", cyc, note_and_pitch, done), "no event");
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event", (e.c == cyc) && (e.np == note_and_pitch) && (e.dn == done),
              $sformatf("cyc=%0d np=%h done=%b", cyc, note_and_pitch, done),
              $sformatf("cyc=%0d np=%h done=%b", e.c, e.np, e.dn));
      end
    end
    prev_np = note_and_pitch;
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] s);
    song_sel = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0;
  int t1;

  initial begin
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 128; a++) begin
        note_mem[s][a] = '0;
        dur_mem[s][a]  = '0;
      end
    end
    note_mem[1][0] = 10'd3;
    note_mem[1][1] = 10'h101; dur_mem[1][1] = 5;
    note_mem[1][2] = 10'h102; dur_mem[1][2] = 5;
    note_mem[1][3] = 10'h103; dur_mem[1][3] = 5;
    note_mem[2][0] = 10'd2;
    note_mem[2][1] = 10'h201; dur_mem[2][1] = 0;
    note_mem[2][2] = 10'h202; dur_mem[2][2] = 3;
    note_mem[3][0] = 10'd0;

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; song_sel = 2'b00;
    @(negedge clk); @(negedge clk);
    check("reset_np",    note_and_pitch == 0, $sformatf("%h", note_and_pitch), "0");
    check("reset_addr",  rom_addr == 0,       $sformatf("%0d", rom_addr), "0");
    check("reset_sel",   rom_sel == 0,        $sformatf("%0d", rom_sel), "0");
    check("reset_index", index == 0,          $sformatf("%0d", index), "0");
    check("reset_busy",  busy == 0,           $sformatf("%b", busy), "0");
    check("reset_done",  done == 0,           $sformatf("%b", done), "0");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal three-note song, with song_sel toggled mid-play
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+2, 10'h101, 0); exp_ev(t0+7, 0, 0);
    exp_ev(t0+12, 10'h102, 0); exp_ev(t0+17, 0, 0);
    exp_ev(t0+22, 10'h103, 0); exp_ev(t0+27, 0, 0);
    exp_ev(t0+31, 0, 1);
    pulse_start(2'b01);
    check("start_addr",  rom_addr == 0, $sformatf("%0d", rom_addr), "0");
    check("start_index", index == 1,    $sformatf("%0d", index), "1");
    check("start_sel",   rom_sel == 1,  $sformatf("%0d", rom_sel), "1");
    check("start_busy",  busy == 1,     $sformatf("%b", busy), "1");
    wait_to(t0+5);  song_sel = 2'b11;
    wait_to(t0+15); check("sel_ignored", rom_sel == 1, $sformatf("%0d", rom_sel), "1");
    song_sel = 2'b10;
    wait_to(t0+33);
    check("nominal_idle",  busy == 0,  $sformatf("%b", busy), "0");
    check("nominal_index", index == 3, $sformatf("%0d", index), "3");

    // Zero-length song
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+1, 0, 1);
    pulse_start(2'b11);
    wait_to(t0+4);
    check("len0_idle", busy == 0, $sformatf("%b", busy), "0");

    // Zero-duration first note
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+2, 10'h201, 0); exp_ev(t0+3, 0, 0);
    exp_ev(t0+8, 10'h202, 0); exp_ev(t0+11, 0, 0);
    exp_ev(t0+15, 0, 1);
    pulse_start(2'b10);
    wait_to(t0+17);

    // Pause on note 2, cycle 2, for 10 cycles
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+2, 10'h101, 0); exp_ev(t0+7, 0, 0);
    exp_ev(t0+12, 10'h102, 0); exp_ev(t0+14, 0, 0);
    exp_ev(t0+24, 10'h102, 0); exp_ev(t0+27, 0, 0);
    exp_ev(t0+32, 10'h103, 0); exp_ev(t0+37, 0, 0);
    exp_ev(t0+41, 0, 1);
    pulse_start(2'b01);
    wait_to(t0+13); pause = 1'b1;
    wait_to(t0+18);
    check("paused_silent", note_and_pitch == 0, $sformatf("%h", note_and_pitch), "0");
    check("paused_busy",   busy == 1,           $sformatf("%b", busy), "1");
    wait_to(t0+23); pause = 1'b0;
    wait_to(t0+43);

    // Stop mid-gap
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+2, 10'h101, 0); exp_ev(t0+7, 0, 0);
    pulse_start(2'b01);
    wait_to(t0+8); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("stop_busy", busy == 0, $sformatf("%b", busy), "0");
    wait_to(t0+40);

    // Restart with a new song while playing
    @(negedge clk);
    t0 = cyc + 1;
    t1 = t0 + 4;
    exp_ev(t0+2, 10'h101, 0); exp_ev(t1, 0, 0);
    exp_ev(t1+2, 10'h201, 0); exp_ev(t1+3, 0, 0);
    exp_ev(t1+8, 10'h202, 0); exp_ev(t1+11, 0, 0);
    exp_ev(t1+15, 0, 1);
    pulse_start(2'b01);
    wait_to(t0+3);
    pulse_start(2'b10);
    check("restart_sel",   rom_sel == 2,  $sformatf("%0d", rom_sel), "2");
    check("restart_addr",  rom_addr == 0, $sformatf("%0d", rom_addr), "0");
    check("restart_index", index == 1,    $sformatf("%0d", index), "1");
    wait_to(t1+17);

    // stop and start on the same edge
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+2, 10'h101, 0); exp_ev(t0+3, 0, 0);
    pulse_start(2'b01);
    wait_to(t0+2);
    stop = 1'b1;
    pulse_start(2'b01);
    stop = 1'b0;
    check("stop_start_busy", busy == 0, $sformatf("%b", busy), "0");
    wait_to(t0+30);

    // start with no song selected from IDLE
    pulse_start(2'b00);
    @(negedge clk);
    check("none_busy", busy == 0,    $sformatf("%b", busy), "0");
    check("none_sel",  rom_sel == 1, $sformatf("%0d", rom_sel), "1");
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-note
    @(negedge clk);
    t0 = cyc + 1;
    exp_ev(t0+2, 10'h101, 0); exp_ev(t0+5, 0, 0);
    pulse_start(2'b01);
    wait_to(t0+4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_np",    note_and_pitch == 0, $sformatf("%h", note_and_pitch), "0");
    check("arst_busy",  busy == 0,           $sformatf("%b", busy), "0");
    check("arst_index", index == 0,          $sformatf("%0d", index), "0");
    check("arst_sel",   rom_sel == 0,        $sformatf("%0d", rom_sel), "0");
    check("arst_addr",  rom_addr == 0,       $sformatf("%0d", rom_addr), "0");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_busy", busy == 0,           $sformatf("%b", busy), "0");
    check("post_reset_np",   note_and_pitch == 0, $sformatf("%h", note_and_pitch), "0");

    repeat (3) @(negedge clk);
    check("events_drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Shared playback controller for the note/duration ROM pair. It fetches the length word, then each note word and its duration, times note-on and inter-note gap, and emits the 10-bit note+pitch bus to the buzzer driver. It sits between the mode FSM (start/pause/stop, song select) and the per-song ROM mux. It replaces the three free-running per-song index counters with a single sequencer that owns one address bus.

## Interface
- `GAP_CYCLES`, default 10_000_000: silent cycles between notes.
- `ROM_LAT`, default 1: ROM read latency in cycles (address registered to data valid); must be ≥1.
- `ADDR_W`, default 7: ROM address width; word 0 holds the note count.
- `DUR_W`, default 32: duration word width, in clock cycles.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; one clock, asynchronous assert, active-low.
- `start` in 1: begin song `song_sel` from note 1; a one-cycle pulse.
- `pause` in 1: level; freezes playback while high.
- `stop` in 1: pulse; aborts to IDLE.
- `song_sel` in 2: 00 none, 01 LittleStar, 10 HappyBirthday, 11 JingleBell; sampled only on `start`.
- `rom_sel` out 2: latched song select driving the ROM mux.
- `rom_addr` out ADDR_W: shared address for the note and duration ROMs.
- `rom_note` in 10: note ROM data {note, pitch}; word 0 low bits = length.
- `rom_dur` in DUR_W: duration ROM data.
- `note_and_pitch` out 10: buzzer bus; 0 = silence.
- `index` out ADDR_W: current note number, for learn-mode display.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the last note's gap completes.

## Operation
- States: IDLE, FETCH_LEN, FETCH_NOTE, PLAY, GAP, PAUSED.
- IDLE:
  - `start` with `song_sel`≠00: latch `rom_sel`, set `index`=1, `rom_addr`=0, go to FETCH_LEN.
  - `start` with `song_sel`=00 is ignored.
- FETCH_LEN: wait ROM_LAT cycles, then capture `length`=`rom_note`[ADDR_W-1:0].
  - `length`=0: pulse `done` and go to IDLE.
  - Otherwise set `rom_addr`=1 and go to FETCH_NOTE.
- FETCH_NOTE: wait ROM_LAT cycles, capture note and duration, clear the counter, go to PLAY.
- PLAY: `note_and_pitch`=captured note. Lasts max(dur,1) cycles; the counter compares against dur−1 with dur=0 treated as 1. Then go to GAP.
- GAP: `note_and_pitch`=0 for GAP_CYCLES cycles. Then:
  - `index`==`length`: pulse `done` and go to IDLE.
  - Otherwise `index`+1, `rom_addr`=`index`+1, go to FETCH_NOTE.
- `index` never exceeds `length`. `length` is clamped to 2^ADDR_W−1; no wrap-around.
- PAUSED:
  - Entered from PLAY, GAP or FETCH_NOTE when `pause` is high.
  - Holds the counters, `index` and the return state; outputs 0.
  - Returns when `pause` falls.
  - A fetch interrupted by pause restarts its ROM_LAT wait on return.
- Priority, highest first: reset > `stop` > `start` > `pause`.
  - `stop` in any state: go to IDLE, output 0, no `done`.
  - `start` while busy: restart from FETCH_LEN with the new `song_sel`. If the new `song_sel`=00, behave as `stop`.
- `song_sel` changes without `start` are ignored.
- Reset values: `note_and_pitch`=0, `rom_addr`=0, `rom_sel`=00, `index`=0, `busy`=0, `done`=0, state IDLE. An asserted `rst_n` mid-note silences the output immediately (asynchronous).

## Timing
- All outputs are registered.
- `start` sampled at edge 0 → `rom_addr`=0 visible after edge 0.
- Length captured at edge ROM_LAT; `rom_addr`=1 after that edge.
- First note visible after edge 2·ROM_LAT.
- Silence between notes = GAP_CYCLES + ROM_LAT cycles.
- `done` is high for the cycle after the last gap's final cycle; `busy` falls on the same edge.
- `stop` sampled at edge k → output 0 and `busy`=0 after edge k.
- `pause` rising at edge k → output 0 after edge k. Falling at edge m → PLAY resumes after edge m with the remaining count intact.

## Structure
- Shared package `piano_pkg`:
  - State enumeration.
  - Song select codes: SONG_NONE, SONG_LS, SONG_HB, SONG_JB.
  - Mode codes, including PLAY_MODE.
  - Default GAP_CYCLES constant.
- One sub-module, `dur_timer`: loadable DUR_W down-counter with hold and expiry flag, instanced once and shared by PLAY and GAP.
- The ROM mux stays outside this block, driven by `rom_sel`.

## Test plan
Common bench settings: GAP_CYCLES=4, ROM_LAT=1, behavioural ROM.
- Nominal: ROM length=3, notes 0x101/0x102/0x103, dur=5.
  - Each note high for 5 cycles, then 5 silent cycles.
  - First note appears 2 cycles after `start`.
  - `done` pulses once; `index` ends at 3.
- Edge lengths and durations:
  - length=0 → `done` 1 cycle after capture, no note output.
  - dur=0 → that note lasts exactly 1 cycle.
- Pause: assert `pause` on note 2, cycle 2, for 10 cycles.
  - Output 0 while paused.
  - After release, note 2 plays its remaining 3 cycles; total span grows by exactly 10.
- Stop and restart:
  - `stop` mid-gap → output 0, `busy`=0 next cycle, no `done`.
  - `start` with `song_sel`=10 while playing song 01 → `rom_sel`=10, `rom_addr`=0, `index`=1.
- Simultaneous inputs and select rules:
  - `stop`+`start` on the same edge → IDLE.
  - `start` with `song_sel`=00 from IDLE → no state change.
  - Toggling `song_sel` without `start` → no effect.
- Reset: assert `rst_n` low asynchronously mid-PLAY.
  - `note_and_pitch`=0 before the next edge; all outputs at their reset values.
  - After release, the block sits in IDLE.
